// File: rtl/ping_pkg.sv
// Shared types and default timing for the PING-style ultrasonic ranging engine.
package ping_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    HOLDOFF,
    WAIT_ECHO,
    MEASURE,
    GUARD,
    PUBLISH
  } state_t;

  localparam int unsigned DEF_CLK_FREQ_MHZ = 100;
  localparam int unsigned DEF_TRIG_US      = 5;
  localparam int unsigned DEF_HOLDOFF_US   = 750;
  localparam int unsigned DEF_TIMEOUT_US   = 18500;
  localparam int unsigned DEF_GUARD_US     = 200;

  localparam int unsigned TIMEOUT_FLAG_BIT = 31;
  localparam int unsigned CNT_W            = 16;

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: counts 0..CLK_FREQ_MHZ-1, pulses us_tick on the
// terminal count, and restarts from 0 whenever restart is asserted.
module us_tick_gen
  import ping_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic us_tick
);

  localparam int unsigned W = $clog2(CLK_FREQ_MHZ);
  localparam logic [W-1:0] LAST = W'(CLK_FREQ_MHZ - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign us_tick = (cnt == LAST);

endmodule

// File: rtl/ping_echo_timer.sv
// Single-pin ultrasonic ranging engine: trigger, blank, time the echo in us.
// Build option PING_TIMEOUT_FLAG_EN: timeouts publish bit 31 set plus the count.
module ping_echo_timer
  import ping_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ,
  parameter int unsigned TRIG_US      = DEF_TRIG_US,
  parameter int unsigned HOLDOFF_US   = DEF_HOLDOFF_US,
  parameter int unsigned TIMEOUT_US   = DEF_TIMEOUT_US,
  parameter int unsigned GUARD_US     = DEF_GUARD_US
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        busy,
  output logic        finish,
  output logic [31:0] out_data,
  inout  wire         sig
);

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_US - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_US - 1);

`ifdef PING_TIMEOUT_FLAG_EN
  localparam logic [31:0] TIMEOUT_CODE =
    (32'd1 << TIMEOUT_FLAG_BIT) | {16'b0, 16'(TIMEOUT_US)};
`else
  localparam logic [31:0] TIMEOUT_CODE = 32'd0;
`endif

  state_t           state, state_nx;
  logic [CNT_W-1:0] us_cnt;
  logic [CNT_W-1:0] width;
  logic             us_tick;
  logic             sig_p0, sig_s, sig_d;
  logic             rise;
  logic             timeout_q;
  logic             latch_width;
  logic             set_timeout;
  logic             restart;

  assign sig     = (state == TRIG) ? 1'b1 : 1'bz;
  assign busy    = (state != IDLE);
  assign rise    = sig_s & ~sig_d;
  assign restart = (state_nx != state);

  // Pin synchronizer; sig_d holds the previous synchronized level for edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sig_p0 <= 1'b0;
      sig_s  <= 1'b0;
      sig_d  <= 1'b0;
    end else begin
      sig_p0 <= sig;
      sig_s  <= sig_p0;
      sig_d  <= sig_s;
    end
  end

  us_tick_gen #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .us_tick(us_tick)
  );

  always_comb begin
    state_nx    = state;
    latch_width = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE:      if (req) state_nx = TRIG;
      TRIG:      if (us_tick && us_cnt == TRIG_LAST) state_nx = HOLDOFF;
      HOLDOFF:   if (us_tick && us_cnt == HOLDOFF_LAST) state_nx = WAIT_ECHO;
      WAIT_ECHO: begin
        if (rise) begin
          state_nx = MEASURE;
        end else if (us_tick && us_cnt == TIMEOUT_LAST) begin
          state_nx    = PUBLISH;
          set_timeout = 1'b1;
        end
      end
      MEASURE: begin
        // The phase counter restarted on entry, so it is the echo width.
        if (!sig_s) begin
          state_nx    = GUARD;
          latch_width = 1'b1;
        end else if (us_tick && us_cnt == TIMEOUT_LAST) begin
          state_nx    = PUBLISH;
          set_timeout = 1'b1;
        end
      end
      GUARD:     if (us_tick && us_cnt == GUARD_LAST) state_nx = PUBLISH;
      PUBLISH:   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      us_cnt    <= '0;
      width     <= '0;
      timeout_q <= 1'b0;
      finish    <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nx;
      if (restart) begin
        us_cnt <= '0;
      end else if (us_tick) begin
        us_cnt <= us_cnt + 1'b1;
      end
      if (state == IDLE && req) begin
        finish    <= 1'b0;
        timeout_q <= 1'b0;
        width     <= '0;
      end
      if (latch_width) width <= us_cnt;
      if (set_timeout) timeout_q <= 1'b1;
      if (state == PUBLISH) begin
        finish   <= 1'b1;
        out_data <= timeout_q ? TIMEOUT_CODE : {{(32-CNT_W){1'b0}}, width};
      end
    end
  end

endmodule
